// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode selectors and
// default almost-full/almost-empty thresholds derived from the address width.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int default_af_thresh(input int unsigned addr_width);
        return (1 << addr_width) - 2;
    endfunction

    function automatic int default_ae_thresh(input int unsigned addr_width);
        return (addr_width == 0) ? 0 : 2;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the FIFO: one synchronous write port and one
// combinational read port.
module fifo_mem #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: binary wrap-bit pointers, registered level,
// threshold flags, sticky error flags, and standard or FWFT read port.
module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int FWFT       = FIFO_STD,
    parameter int AF_THRESH  = default_af_thresh(ADDR_WIDTH),
    parameter int AE_THRESH  = default_ae_thresh(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_push,
    output logic                  w_full,
    output logic                  w_almost_full,
    input  logic                  r_pop,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  r_empty,
    output logic                  r_almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam logic [ADDR_WIDTH:0] AF_LVL   = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_LVL   = AE_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PTR_INC  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   level_q;
    logic                  push_ok;
    logic                  pop_ok;
    logic [DATA_WIDTH-1:0] mem_rd;

    // Flags depend only on registered pointers/level, never on this cycle's requests.
    assign w_full         = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                            (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign r_empty        = (wr_ptr == rd_ptr);
    assign w_almost_full  = (level_q >= AF_LVL);
    assign r_almost_empty = (level_q <= AE_LVL);
    assign level          = level_q;

    assign push_ok = w_push & ~w_full;
    assign pop_ok  = r_pop & ~r_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_INC;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_INC;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + PTR_INC;
                2'b01:   level_q <= level_q - PTR_INC;
                default: level_q <= level_q;
            endcase
        end
    end

    // A new error in the same cycle as clr_err takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (w_push & w_full)  | (overflow  & ~clr_err);
            underflow <= (r_pop  & r_empty) | (underflow & ~clr_err);
        end
    end

    fifo_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (w_data),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (mem_rd)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign r_data  = mem_rd;
            assign r_valid = ~r_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_q;
            logic                  r_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else begin
                    r_valid_q <= pop_ok;
                    if (pop_ok) r_data_q <= mem_rd;
                end
            end

            assign r_data  = r_data_q;
            assign r_valid = r_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed bench: one standard-read and one FWFT instance share stimulus,
// each checked against hand-computed expectations.
module tb_fifo_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] w_data;
    logic       w_push;
    logic       r_pop;
    logic       clr_err;

    logic       full_s, af_s, empty_s, ae_s, valid_s, ovf_s, unf_s;
    logic       full_f, af_f, empty_f, ae_f, valid_f, ovf_f, unf_f;
    logic [7:0] data_s, data_f;
    logic [3:0] lvl_s, lvl_f;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fifo_sync_ctrl #(
        .ADDR_WIDTH (3), .DATA_WIDTH (8), .FWFT (0), .AF_THRESH (6), .AE_THRESH (2)
    ) u_std (
        .clk (clk), .rst_n (rst_n), .w_data (w_data), .w_push (w_push),
        .w_full (full_s), .w_almost_full (af_s), .r_pop (r_pop), .r_data (data_s),
        .r_valid (valid_s), .r_empty (empty_s), .r_almost_empty (ae_s), .level (lvl_s),
        .overflow (ovf_s), .underflow (unf_s), .clr_err (clr_err)
    );

    fifo_sync_ctrl #(
        .ADDR_WIDTH (3), .DATA_WIDTH (8), .FWFT (1), .AF_THRESH (6), .AE_THRESH (2)
    ) u_fwft (
        .clk (clk), .rst_n (rst_n), .w_data (w_data), .w_push (w_push),
        .w_full (full_f), .w_almost_full (af_f), .r_pop (r_pop), .r_data (data_f),
        .r_valid (valid_f), .r_empty (empty_f), .r_almost_empty (ae_f), .level (lvl_f),
        .overflow (ovf_f), .underflow (unf_f), .clr_err (clr_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; w_data = '0; w_push = 1'b0; r_pop = 1'b0; clr_err = 1'b0;
        #12;
        total++;
        if ({lvl_s, lvl_f} !== 8'h00)
            $display("FAIL reset_level std=%0d fwft=%0d exp=0", lvl_s, lvl_f);
        else passed++;
        total++;
        if ({empty_s, ae_s, full_s, af_s, empty_f, ae_f, full_f, af_f} !== 8'b1100_1100)
            $display("FAIL reset_flags got=%b exp=11001100",
                     {empty_s, ae_s, full_s, af_s, empty_f, ae_f, full_f, af_f});
        else passed++;
        total++;
        if ({data_s, valid_s, valid_f, ovf_s, unf_s, ovf_f, unf_f} !== 14'h0)
            $display("FAIL reset_rdata_err data=%h valid=%b%b err=%b%b%b%b exp=0",
                     data_s, valid_s, valid_f, ovf_s, unf_s, ovf_f, unf_f);
        else passed++;
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 8; i++) begin
            w_data = 8'(i); w_push = 1'b1;
            tick();
            total++;
            if ({lvl_s, lvl_f} !== {4'(i), 4'(i)})
                $display("FAIL fill_level i=%0d std=%0d fwft=%0d exp=%0d", i, lvl_s, lvl_f, i);
            else passed++;
            total++;
            if ({af_s, af_f, full_s, full_f} !== {{2{i >= 6}}, {2{i == 8}}})
                $display("FAIL fill_flags i=%0d af=%b%b full=%b%b exp_af=%0b exp_full=%0b",
                         i, af_s, af_f, full_s, full_f, i >= 6, i == 8);
            else passed++;
        end
        w_data = 8'h09;
        tick();
        w_push = 1'b0;
        total++;
        if ({ovf_s, ovf_f, lvl_s, lvl_f} !== {2'b11, 4'd8, 4'd8})
            $display("FAIL overflow_push ovf=%b%b level=%0d/%0d exp ovf=11 level=8",
                     ovf_s, ovf_f, lvl_s, lvl_f);
        else passed++;
    endtask

    task automatic test_drain;
        for (int i = 1; i <= 8; i++) begin
            total++;
            if ({data_f, valid_f} !== {8'(i), 1'b1})
                $display("FAIL fwft_head i=%0d data=%h valid=%b exp=%h/1", i, data_f, valid_f, 8'(i));
            else passed++;
            r_pop = 1'b1;
            tick();
            total++;
            if ({data_s, valid_s} !== {8'(i), 1'b1})
                $display("FAIL std_read i=%0d data=%h valid=%b exp=%h/1", i, data_s, valid_s, 8'(i));
            else passed++;
            total++;
            if ({lvl_s, lvl_f} !== {4'(8 - i), 4'(8 - i)})
                $display("FAIL drain_level i=%0d std=%0d fwft=%0d exp=%0d", i, lvl_s, lvl_f, 8 - i);
            else passed++;
        end
        r_pop = 1'b0;
        tick();
        total++;
        if ({valid_s, valid_f, empty_s, empty_f, data_s} !== {4'b0011, 8'h08})
            $display("FAIL drained_state valid=%b%b empty=%b%b data=%h exp valid=00 empty=11 data=08",
                     valid_s, valid_f, empty_s, empty_f, data_s);
        else passed++;
        r_pop = 1'b1;
        tick();
        r_pop = 1'b0;
        total++;
        if ({unf_s, unf_f, valid_s, data_s, lvl_s, lvl_f} !== {3'b110, 8'h08, 8'h00})
            $display("FAIL underflow_pop unf=%b%b valid=%b data=%h level=%0d/%0d exp unf=11 valid=0 data=08 level=0",
                     unf_s, unf_f, valid_s, data_s, lvl_s, lvl_f);
        else passed++;
    endtask

    task automatic test_stream;
        for (int i = 0; i < 4; i++) begin
            w_data = 8'(8'h10 + i); w_push = 1'b1;
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            w_data = 8'(8'h14 + k); w_push = 1'b1; r_pop = 1'b1;
            total++;
            if (data_f !== 8'(8'h10 + k))
                $display("FAIL stream_fwft k=%0d data=%h exp=%h", k, data_f, 8'(8'h10 + k));
            else passed++;
            tick();
            total++;
            if ({data_s, valid_s} !== {8'(8'h10 + k), 1'b1})
                $display("FAIL stream_std k=%0d data=%h valid=%b exp=%h/1", k, data_s, valid_s, 8'(8'h10 + k));
            else passed++;
            total++;
            if ({lvl_s, lvl_f, full_s, empty_s, af_s, ae_s, full_f, empty_f, af_f, ae_f} !== {4'd4, 4'd4, 8'h00})
                $display("FAIL stream_state k=%0d level=%0d/%0d flags=%b exp level=4 flags=0",
                         k, lvl_s, lvl_f, {full_s, empty_s, af_s, ae_s, full_f, empty_f, af_f, ae_f});
            else passed++;
        end
        w_push = 1'b0; r_pop = 1'b0;
    endtask

    task automatic test_simultaneous;
        // Holds 0x38..0x3B; top up to full with 0x3C..0x3F.
        for (int i = 0; i < 4; i++) begin
            w_data = 8'(8'h3C + i); w_push = 1'b1;
            tick();
        end
        total++;
        if ({full_s, full_f} !== 2'b11)
            $display("FAIL topup_full full=%b%b exp=11", full_s, full_f);
        else passed++;
        w_data = 8'hEE; w_push = 1'b1; r_pop = 1'b1;
        tick();
        w_push = 1'b0; r_pop = 1'b0;
        total++;
        if ({lvl_s, lvl_f, full_s, full_f, ovf_s, ovf_f, data_s} !== {4'd7, 4'd7, 4'b0011, 8'h38})
            $display("FAIL full_pushpop level=%0d/%0d full=%b%b ovf=%b%b data=%h exp level=7 full=00 ovf=11 data=38",
                     lvl_s, lvl_f, full_s, full_f, ovf_s, ovf_f, data_s);
        else passed++;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (data_f !== 8'(8'h39 + i))
                $display("FAIL full_drain_fwft i=%0d data=%h exp=%h", i, data_f, 8'(8'h39 + i));
            else passed++;
            r_pop = 1'b1;
            tick();
            total++;
            if (data_s !== 8'(8'h39 + i))
                $display("FAIL full_drain_std i=%0d data=%h exp=%h", i, data_s, 8'(8'h39 + i));
            else passed++;
        end
        w_data = 8'h77; w_push = 1'b1; r_pop = 1'b1;
        tick();
        w_push = 1'b0; r_pop = 1'b0;
        total++;
        if ({lvl_s, lvl_f, empty_s, empty_f, unf_s, unf_f, valid_s} !== {4'd1, 4'd1, 5'b00110})
            $display("FAIL empty_pushpop level=%0d/%0d empty=%b%b unf=%b%b valid=%b exp level=1 empty=00 unf=11 valid=0",
                     lvl_s, lvl_f, empty_s, empty_f, unf_s, unf_f, valid_s);
        else passed++;
        total++;
        if (data_f !== 8'h77)
            $display("FAIL empty_pushpop_word data=%h exp=77", data_f);
        else passed++;
        r_pop = 1'b1;
        tick();
        r_pop = 1'b0;
        total++;
        if ({data_s, empty_s, empty_f} !== {8'h77, 2'b11})
            $display("FAIL empty_pushpop_read data=%h empty=%b%b exp=77/11", data_s, empty_s, empty_f);
        else passed++;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            w_data = 8'(8'h50 + i); w_push = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({lvl_s, lvl_f, empty_s, ae_s, full_s, af_s, empty_f, ae_f, full_f, af_f} !== {8'h00, 8'b1100_1100})
            $display("FAIL midreset_state level=%0d/%0d flags=%b exp level=0 flags=11001100",
                     lvl_s, lvl_f, {empty_s, ae_s, full_s, af_s, empty_f, ae_f, full_f, af_f});
        else passed++;
        total++;
        if ({data_s, valid_s, valid_f, ovf_s, unf_s, ovf_f, unf_f} !== 14'h0)
            $display("FAIL midreset_outputs data=%h valid=%b%b err=%b%b%b%b exp=0",
                     data_s, valid_s, valid_f, ovf_s, unf_s, ovf_f, unf_f);
        else passed++;
        w_push = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        w_data = 8'hA5; w_push = 1'b1;
        tick();
        w_push = 1'b0;
        total++;
        if ({lvl_s, lvl_f, data_f} !== {4'd1, 4'd1, 8'hA5})
            $display("FAIL postreset_push level=%0d/%0d fwft_data=%h exp level=1 data=a5", lvl_s, lvl_f, data_f);
        else passed++;
        r_pop = 1'b1;
        tick();
        r_pop = 1'b0;
        total++;
        if ({data_s, valid_s, empty_s, empty_f} !== {8'hA5, 3'b111})
            $display("FAIL postreset_read data=%h valid=%b empty=%b%b exp=a5/1/11", data_s, valid_s, empty_s, empty_f);
        else passed++;
    endtask

    task automatic test_err_clear;
        for (int i = 0; i < 9; i++) begin
            w_data = 8'(8'hC0 + i); w_push = 1'b1;
            tick();
        end
        w_push = 1'b0;
        total++;
        if ({ovf_s, ovf_f} !== 2'b11)
            $display("FAIL err_set ovf=%b%b exp=11", ovf_s, ovf_f);
        else passed++;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        total++;
        if ({ovf_s, ovf_f, lvl_s, lvl_f} !== {2'b00, 4'd8, 4'd8})
            $display("FAIL err_clear ovf=%b%b level=%0d/%0d exp ovf=00 level=8", ovf_s, ovf_f, lvl_s, lvl_f);
        else passed++;
        clr_err = 1'b1; w_push = 1'b1;
        tick();
        clr_err = 1'b0; w_push = 1'b0;
        total++;
        if ({ovf_s, ovf_f} !== 2'b11)
            $display("FAIL err_set_wins ovf=%b%b exp=11", ovf_s, ovf_f);
        else passed++;
        tick();
        total++;
        if ({ovf_s, ovf_f, unf_s, unf_f} !== 4'b1100)
            $display("FAIL err_sticky ovf=%b%b unf=%b%b exp ovf=11 unf=00", ovf_s, ovf_f, unf_s, unf_f);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_simultaneous();
        test_reset_mid();
        test_err_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
